uart_nand_cmd_bridge: RTL and testbench



---
 rtl/nand_bridge_pkg.sv | 25 ++
 rtl/uart_reg_port.sv | 57 +++++
 rtl/uart_nand_cmd_bridge.sv | 163 ++++++++++++++++
 tb/tb_uart_nand_cmd_bridge.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_bridge_pkg.sv
// Shared types and constants for the UART-to-NAND command bridge.
// Bytes arrive from and return to the simpleuart register port.
package nand_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_DATA,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        TX_STAT,
        TX_DATA
    } state_t;

    localparam logic [7:0]  ST_OK      = 8'h00;
    localparam logic [7:0]  ST_NOSTART = 8'hE1;
    localparam logic [7:0]  ST_TIMEOUT = 8'hE2;
    localparam logic [31:0] RX_EMPTY   = 32'hFFFF_FFFF;

    function automatic logic [31:0] tx_word(input logic [7:0] b);
        return {24'h00_0000, b};
    endfunction

endpackage

// File: rtl/uart_reg_port.sv
// simpleuart register-port adapter: RX pop with one blanking cycle after each pop,
// and a TX write request held under backpressure until it has been accepted.
module uart_reg_port
    import nand_bridge_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_reg_dat_do,
    output logic        o_reg_dat_re,
    output logic [31:0] o_reg_dat_di,
    output logic        o_reg_dat_we,
    input  logic        i_reg_dat_wait,
    output logic        o_rx_valid,
    output logic [7:0]  o_rx_byte,
    input  logic        i_rx_ack,
    input  logic        i_tx_req,
    input  logic [7:0]  i_tx_byte,
    output logic        o_tx_done
);

    logic        r_blank;
    logic        r_we;
    logic [31:0] r_di;
    logic        w_pop;

    // Blank starts set so nothing is popped in the first cycle after reset.
    assign o_rx_valid   = !i_reset && !r_blank && (i_reg_dat_do != RX_EMPTY);
    assign o_rx_byte    = i_reg_dat_do[7:0];
    assign w_pop        = o_rx_valid && i_rx_ack;
    assign o_reg_dat_re = w_pop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_blank <= 1'b1;
        end else begin
            r_blank <= w_pop;
        end
    end

    assign o_tx_done    = r_we && !i_reg_dat_wait;
    assign o_reg_dat_we = r_we;
    assign o_reg_dat_di = r_di;

    // A completed write always drops we for a cycle, so one request gives one write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_we <= 1'b0;
            r_di <= 32'h0000_0000;
        end else if (o_tx_done) begin
            r_we <= 1'b0;
        end else if (i_tx_req && !r_we) begin
            r_we <= 1'b1;
            r_di <= tx_word(i_tx_byte);
        end
    end

endmodule

// File: rtl/uart_nand_cmd_bridge.sv
// Framed bridge: SYNC, cmd, data from UART -> one nand_master command -> status and
// read data back to UART.
module uart_nand_cmd_bridge
    import nand_bridge_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned BYTE_TIMEOUT = 120000,
    parameter int unsigned START_WAIT   = 16,
    parameter int unsigned BUSY_TIMEOUT = 1200000,
    parameter int unsigned CW           = 24
) (
    input  logic        hw_clk,
    input  logic        reset,
    input  logic [31:0] reg_dat_do,
    output logic        reg_dat_re,
    output logic [31:0] reg_dat_di,
    output logic        reg_dat_we,
    input  logic        reg_dat_wait,
    output logic [7:0]  cmd_in,
    output logic [7:0]  data_in,
    output logic        activate,
    input  logic        busy,
    input  logic [7:0]  data_out,
    output logic        frame_err
);

    localparam logic [CW-1:0] L_BYTE_TO  = CW'(BYTE_TIMEOUT);
    localparam logic [CW-1:0] L_START_TO = CW'(START_WAIT);
    localparam logic [CW-1:0] L_BUSY_TO  = CW'(BUSY_TIMEOUT);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_cmd;
    logic [7:0]    r_data;
    logic [7:0]    r_status;
    logic [7:0]    r_rdata;

    logic          w_rx_valid;
    logic [7:0]    w_rx_byte;
    logic          w_rx_ack;
    logic          w_tx_req;
    logic [7:0]    w_tx_byte;
    logic          w_tx_done;
    logic          w_byte_to;
    logic          w_start_to;
    logic          w_busy_to;
    logic          w_cnt_clr;

    uart_reg_port u_port (
        .i_clk          (hw_clk),
        .i_reset        (reset),
        .i_reg_dat_do   (reg_dat_do),
        .o_reg_dat_re   (reg_dat_re),
        .o_reg_dat_di   (reg_dat_di),
        .o_reg_dat_we   (reg_dat_we),
        .i_reg_dat_wait (reg_dat_wait),
        .o_rx_valid     (w_rx_valid),
        .o_rx_byte      (w_rx_byte),
        .i_rx_ack       (w_rx_ack),
        .i_tx_req       (w_tx_req),
        .i_tx_byte      (w_tx_byte),
        .o_tx_done      (w_tx_done)
    );

    assign w_byte_to  = (r_cnt >= L_BYTE_TO);
    assign w_start_to = (r_cnt >= L_START_TO);
    assign w_busy_to  = (r_cnt >= L_BUSY_TO);
    // Every state change restarts the timeout window.
    assign w_cnt_clr  = (w_state_next != r_state) || (r_state == IDLE);

    always_ff @(posedge hw_clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_rx_valid && (w_rx_byte == SYNC_BYTE)) w_state_next = GET_CMD;
            end
            GET_CMD: begin
                if (w_rx_valid)     w_state_next = GET_DATA;
                else if (w_byte_to) w_state_next = IDLE;
            end
            GET_DATA: begin
                if (w_rx_valid)     w_state_next = ISSUE;
                else if (w_byte_to) w_state_next = IDLE;
            end
            ISSUE: w_state_next = WAIT_HI;
            WAIT_HI: begin
                if (busy)            w_state_next = WAIT_LO;
                else if (w_start_to) w_state_next = TX_STAT;
            end
            WAIT_LO: begin
                if (!busy || w_busy_to) w_state_next = TX_STAT;
            end
            TX_STAT: begin
                if (w_tx_done) w_state_next = TX_DATA;
            end
            TX_DATA: begin
                if (w_tx_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_rx_ack  = (r_state == IDLE) || (r_state == GET_CMD) || (r_state == GET_DATA);
        w_tx_req  = (r_state == TX_STAT) || (r_state == TX_DATA);
        w_tx_byte = (r_state == TX_DATA) ? r_rdata : r_status;
        activate  = (r_state == ISSUE);
        frame_err = ((r_state == GET_CMD) || (r_state == GET_DATA)) && !w_rx_valid && w_byte_to;
    end

    always_ff @(posedge hw_clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_cmd    <= 8'h00;
            r_data   <= 8'h00;
            r_status <= 8'h00;
            r_rdata  <= 8'h00;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_cnt != {CW{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                GET_CMD: begin
                    if (w_rx_valid) r_cmd <= w_rx_byte;
                end
                GET_DATA: begin
                    if (w_rx_valid) r_data <= w_rx_byte;
                end
                // Cleared here so a no-start response carries a zero data byte.
                ISSUE: r_rdata <= 8'h00;
                WAIT_HI: begin
                    if (!busy && w_start_to) r_status <= ST_NOSTART;
                end
                WAIT_LO: begin
                    if (!busy) begin
                        r_status <= ST_OK;
                        r_rdata  <= data_out;
                    end else if (w_busy_to) begin
                        r_status <= ST_TIMEOUT;
                        r_rdata  <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_in  = r_cmd;
    assign data_in = r_data;

endmodule

// File: tb/tb_uart_nand_cmd_bridge.sv
// Directed bench: a simpleuart FIFO model, a nand_master busy model and a TX scoreboard.
module tb_uart_nand_cmd_bridge;

    logic        hw_clk;
    logic        reset;
    logic [31:0] reg_dat_do = 32'hFFFF_FFFF;
    logic        reg_dat_re;
    logic [31:0] reg_dat_di;
    logic        reg_dat_we;
    logic        reg_dat_wait;
    logic [7:0]  cmd_in;
    logic [7:0]  data_in;
    logic        activate;
    logic        busy;
    logic [7:0]  data_out;
    logic        frame_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  rx_q[$];
    int          rx_rd = 0;
    logic [31:0] tx_got[$];
    int          tx_rd = 0;
    logic [31:0] exp_q[$];

    int   act_cnt  = 0;
    int   ferr_cnt = 0;
    int   lat_err  = 0;
    logic prev_re  = 1'b0;

    int bmode = 0;
    int bhold = 50;
    int bt    = 0;

    uart_nand_cmd_bridge #(
        .BYTE_TIMEOUT (200),
        .BUSY_TIMEOUT (100)
    ) dut (
        .hw_clk       (hw_clk),
        .reset        (reset),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_wait (reg_dat_wait),
        .cmd_in       (cmd_in),
        .data_in      (data_in),
        .activate     (activate),
        .busy         (busy),
        .data_out     (data_out),
        .frame_err    (frame_err)
    );

    initial begin
        hw_clk = 1'b0;
        forever #5 hw_clk = ~hw_clk;
    end

    // simpleuart RX FIFO: the head is presented from the edge after it is queued.
    always @(posedge hw_clk) begin
        if (reg_dat_re && rx_rd < rx_q.size()) rx_rd = rx_rd + 1;
        if (rx_rd < rx_q.size()) reg_dat_do <= {24'h00_0000, rx_q[rx_rd]};
        else                     reg_dat_do <= 32'hFFFF_FFFF;
    end

    // nand_master: mode 0 pulses busy 2 cycles after activate for bhold cycles,
    // mode 1 never raises busy, mode 2 raises it and keeps it high.
    always @(posedge hw_clk) begin
        if (reset) begin
            bt = 0;
            busy <= 1'b0;
        end else begin
            if (activate)     bt = 1;
            else if (bt != 0) bt = bt + 1;
            case (bmode)
                0:       busy <= (bt >= 2) && (bt < 2 + bhold);
                2:       busy <= (bt >= 2);
                default: busy <= 1'b0;
            endcase
        end
    end

    always @(posedge hw_clk) begin
        if (reg_dat_we && !reg_dat_wait) tx_got.push_back(reg_dat_di);
        if (activate) act_cnt = act_cnt + 1;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (activate && !prev_re) lat_err = lat_err + 1;
        prev_re = reg_dat_re;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        rx_q.push_back(a);
        rx_q.push_back(b);
        rx_q.push_back(c);
    endtask

    task automatic drain_sb(input string tag);
        int n;
        while (exp_q.size() > 0) begin
            n = 0;
            while (tx_got.size() <= tx_rd && n < 3000) begin
                @(negedge hw_clk);
                n++;
            end
            if (tx_got.size() <= tx_rd) begin
                check({tag, "_tx_timeout"}, tx_got.size(), tx_rd + 1);
                exp_q.delete();
                return;
            end
            check(tag, tx_got[tx_rd], exp_q.pop_front());
            tx_rd++;
        end
        repeat (4) @(negedge hw_clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_re"},    reg_dat_re, 1'b0);
        check({tag, "_we"},    reg_dat_we, 1'b0);
        check({tag, "_di"},    reg_dat_di, 32'h0);
        check({tag, "_cmd"},   cmd_in, 8'h00);
        check({tag, "_data"},  data_in, 8'h00);
        check({tag, "_act"},   activate, 1'b0);
        check({tag, "_ferr"},  frame_err, 1'b0);
    endtask

    initial begin
        int a0;
        int f0;
        int t0;
        int n;
        logic [31:0] di_hold;

        reset        = 1'b1;
        reg_dat_wait = 1'b0;
        data_out     = 8'h00;
        repeat (3) @(negedge hw_clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(negedge hw_clk);

        // Normal frame.
        bmode = 0; bhold = 50; data_out = 8'h98;
        a0 = act_cnt; f0 = ferr_cnt;
        exp_q.push_back(32'h00); exp_q.push_back(32'h98);
        send3(8'hA5, 8'h70, 8'h00);
        drain_sb("normal_tx");
        check("normal_cmd", cmd_in, 8'h70);
        check("normal_data", data_in, 8'h00);
        check("normal_act", act_cnt - a0, 1);
        check("normal_ferr", ferr_cnt - f0, 0);

        // Garbage ahead of the frame is dropped.
        data_out = 8'h3C;
        a0 = act_cnt; f0 = ferr_cnt;
        exp_q.push_back(32'h00); exp_q.push_back(32'h3C);
        rx_q.push_back(8'h13); rx_q.push_back(8'hFF);
        send3(8'hA5, 8'h90, 8'h00);
        drain_sb("garbage_tx");
        check("garbage_cmd", cmd_in, 8'h90);
        check("garbage_act", act_cnt - a0, 1);
        check("garbage_ferr", ferr_cnt - f0, 0);
        check("garbage_rx_drained", rx_rd, rx_q.size());

        // Inter-byte timeout, then a clean frame.
        a0 = act_cnt; f0 = ferr_cnt; t0 = tx_got.size();
        rx_q.push_back(8'hA5); rx_q.push_back(8'h80);
        repeat (400) @(negedge hw_clk);
        check("to_ferr", ferr_cnt - f0, 1);
        check("to_act", act_cnt - a0, 0);
        check("to_no_tx", tx_got.size(), t0);
        data_out = 8'h55;
        exp_q.push_back(32'h00); exp_q.push_back(32'h55);
        send3(8'hA5, 8'hFF, 8'h00);
        drain_sb("after_to_tx");
        check("after_to_cmd", cmd_in, 8'hFF);
        check("after_to_data", data_in, 8'h00);
        check("after_to_act", act_cnt - a0, 1);

        // Busy never rises.
        bmode = 1;
        exp_q.push_back(32'hE1); exp_q.push_back(32'h00);
        send3(8'hA5, 8'h11, 8'h22);
        drain_sb("nostart_tx");
        check("nostart_data", data_in, 8'h22);

        // Busy stuck high.
        bmode = 2;
        exp_q.push_back(32'hE2); exp_q.push_back(32'h00);
        send3(8'hA5, 8'h12, 8'h34);
        drain_sb("stuck_tx");
        bmode = 0;
        repeat (2) @(negedge hw_clk);

        // Backpressure on the status write.
        data_out = 8'h77;
        reg_dat_wait = 1'b1;
        t0 = tx_got.size();
        exp_q.push_back(32'h00); exp_q.push_back(32'h77);
        send3(8'hA5, 8'h21, 8'h43);
        n = 0;
        while (!reg_dat_we && n < 500) begin
            @(negedge hw_clk);
            n++;
        end
        check("bp_we_rise", reg_dat_we, 1'b1);
        check("bp_di_status", reg_dat_di, 32'h00);
        di_hold = reg_dat_di;
        for (int i = 0; i < 30; i++) begin
            @(negedge hw_clk);
            check("bp_we_hold", reg_dat_we, 1'b1);
            check("bp_di_hold", reg_dat_di, di_hold);
        end
        check("bp_no_write", tx_got.size(), t0);
        reg_dat_wait = 1'b0;
        drain_sb("bp_tx");
        check("bp_two_writes", tx_got.size() - t0, 2);

        // Reset while waiting for busy to fall.
        bmode = 0; bhold = 50; data_out = 8'hAB;
        send3(8'hA5, 8'h33, 8'h44);
        n = 0;
        while (!busy && n < 200) begin
            @(negedge hw_clk);
            n++;
        end
        check("rst_busy_seen", busy, 1'b1);
        repeat (5) @(negedge hw_clk);
        t0 = tx_got.size(); a0 = act_cnt;
        reset = 1'b1;
        @(posedge hw_clk);
        #1;
        check_outputs_zero("rst_mid");
        @(negedge hw_clk);
        reset = 1'b0;
        repeat (120) @(negedge hw_clk);
        check("rst_no_tx", tx_got.size(), t0);
        check("rst_no_act", act_cnt, a0);

        check("total_writes", tx_got.size(), 12);
        check("activate_latency", lat_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
